register_file_2r1w: RTL
=======================

REGISTER_FILE_2R1W -- requirements
Module: register_file_2r1w

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, bit width of each register.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 2, register index width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL provide parameter ZERO_REG, default 0; when 1, register 0 reads as 0 and ignores writes/reserves.
REQ-004 SHALL provide port clock  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL provide port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL provide port read_register_port_0  input  ADDR_WIDTH  read port 0 index.
REQ-007 SHALL provide port read_register_port_1  input  ADDR_WIDTH  read port 1 index.
REQ-008 SHALL provide port write_register  input  ADDR_WIDTH  write index.
REQ-009 SHALL provide port write_data  input  DATA_WIDTH  write value.
REQ-010 SHALL provide port write_enable  input  1  write strobe, sampled at rising edge.
REQ-011 SHALL provide port reserve_register  input  ADDR_WIDTH  register to mark pending.
REQ-012 SHALL provide port reserve_enable  input  1  reserve strobe, sampled at rising edge.
REQ-013 SHALL provide port read_data_port_0  output  DATA_WIDTH  registered read data, port 0.
REQ-014 SHALL provide port read_data_port_1  output  DATA_WIDTH  registered read data, port 1.
REQ-015 SHALL provide port read_pending_port_0  output  1  registered pending flag of port 0 register.
REQ-016 SHALL provide port read_pending_port_1  output  1  registered pending flag of port 1 register.

Function
REQ-017 SHALL hold 2**ADDR_WIDTH data registers of DATA_WIDTH bits plus one pending bit per register.
REQ-018 SHALL, at a rising edge with write_enable=1, store write_data into register write_register and clear its pending bit.
REQ-019 SHALL, at a rising edge with reserve_enable=1, set the pending bit of reserve_register.
REQ-020 SHALL, on same-edge reserve and write to the same register, store the data and leave the pending bit set (reserve wins).
REQ-021 SHALL sample both read indices at each rising edge and present data and pending flag after that edge; read latency exactly 1 cycle, no enable, outputs update every cycle.
REQ-022 SHALL bypass: when a read index equals write_register with write_enable=1 at the same edge, the read port outputs write_data, not the old value.
REQ-023 SHALL apply the same bypass to pending flags: a read port reflects the pending state after that edge's write and reserve.
REQ-024 SHALL allow both read ports to address the same register, returning identical data and flags.
REQ-025 SHALL, with ZERO_REG=1, ignore writes and reserves to index 0 and return data 0 and pending 0 for index 0, including under bypass.
REQ-026 SHALL, with ZERO_REG=0, treat index 0 as an ordinary register.
REQ-027 SHALL leave all state unchanged at edges where write_enable=0 and reserve_enable=0, apart from read output refresh.

Reset
REQ-028 SHALL, while reset_n=0, immediately force all data registers to 0, all pending bits to 0, and read_data_port_0/1 and read_pending_port_0/1 to 0.
REQ-029 SHALL ignore write_enable and reserve_enable while reset_n=0; a write in progress at reset assertion is discarded.
REQ-030 SHALL resume normal operation at the first rising edge at which reset_n=1.

Verification
REQ-031 SHALL cover fill and readback: write 21,42,84,168 to registers 0..3 on consecutive edges, then read 0/1 and 2/3 -> ports return 21/42 then 84/168, one cycle after index is presented.
REQ-032 SHALL cover bypass: register 2 holds 84; same edge write 99 to 2 and read port 0 index 2 -> read_data_port_0=99 after that edge.
REQ-033 SHALL cover scoreboard: reserve 1 -> read_pending for index 1 = 1 next cycle; write 7 to 1 -> pending 0 and data 7 next cycle; same-edge reserve+write 1 -> data 7, pending 1.
REQ-034 SHALL cover ZERO_REG=1: write 55 and reserve to index 0 -> both ports on index 0 read 0, pending 0.
REQ-035 SHALL cover reset mid-operation: after registers hold 21..168 and register 3 pending, assert reset_n=0 between edges -> all outputs 0 immediately, subsequent reads of 0..3 return 0, pending 0.

Source files
------------

// File: rtl/register_file_2r1w.sv
// register_file_2r1w: 2-read/1-write register file with per-register pending bits.
// Ports: clock, reset_n, read_register_port_0/1, write_register/data/enable,
//        reserve_register/enable, read_data_port_0/1, read_pending_port_0/1.
module register_file_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2,
    parameter bit ZERO_REG   = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] read_register_port_0,
    input  logic [ADDR_WIDTH-1:0] read_register_port_1,
    input  logic [ADDR_WIDTH-1:0] write_register,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] reserve_register,
    input  logic                  reserve_enable,
    output logic [DATA_WIDTH-1:0] read_data_port_0,
    output logic [DATA_WIDTH-1:0] read_data_port_1,
    output logic                  read_pending_port_0,
    output logic                  read_pending_port_1
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      pend_q;

    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]      pend_d;

    logic                  write_ok;
    logic                  reserve_ok;
    logic [DATA_WIDTH-1:0] rd0_d;
    logic [DATA_WIDTH-1:0] rd1_d;
    logic                  rp0_d;
    logic                  rp1_d;

    assign write_ok   = write_enable &&
                        !(ZERO_REG && write_register == '0);
    assign reserve_ok = reserve_enable &&
                        !(ZERO_REG && reserve_register == '0);

    // Post-edge state; reads sample this so bypass falls out naturally.
    // Reserve is applied after write so it wins on a collision.
    always_comb begin
        data_d = data_q;
        pend_d = pend_q;
        if (write_ok) begin
            data_d[write_register] = write_data;
            pend_d[write_register] = 1'b0;
        end
        if (reserve_ok) begin
            pend_d[reserve_register] = 1'b1;
        end
    end

    always_comb begin
        rd0_d = data_d[read_register_port_0];
        rd1_d = data_d[read_register_port_1];
        rp0_d = pend_d[read_register_port_0];
        rp1_d = pend_d[read_register_port_1];
        if (ZERO_REG && read_register_port_0 == '0) begin
            rd0_d = '0;
            rp0_d = 1'b0;
        end
        if (ZERO_REG && read_register_port_1 == '0) begin
            rd1_d = '0;
            rp1_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            pend_q              <= '0;
            read_data_port_0    <= '0;
            read_data_port_1    <= '0;
            read_pending_port_0 <= 1'b0;
            read_pending_port_1 <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            pend_q              <= pend_d;
            read_data_port_0    <= rd0_d;
            read_data_port_1    <= rd1_d;
            read_pending_port_0 <= rp0_d;
            read_pending_port_1 <= rp1_d;
        end
    end

endmodule
